uart_spi_cmd_ctrl: RTL

UART_SPI_CMD_CTRL -- requirements
Module: uart_spi_cmd_ctrl

---
 rtl/uart_spi_cmd_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_spi_cmd_ctrl.sv
// UART-to-SPI command bridge: collects a header-described frame from the UART, writes each
// payload byte over SPI under one chip-select window and optionally echoes SPI replies to UART.
module uart_spi_cmd_ctrl #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 1740
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    output logic       spi_start_o,
    output logic [7:0] spi_tx_data_o,
    input  logic       spi_busy_i,
    input  logic       spi_done_i,
    input  logic [7:0] spi_rx_data_i,
    output logic       spi_cs_n_o,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_busy_i,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned IdxW  = $clog2(MAX_LEN + 1);
    localparam int unsigned AddrW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCollect = 3'd1;
    localparam logic [2:0] StCsSetup = 3'd2;
    localparam logic [2:0] StIssue   = 3'd3;
    localparam logic [2:0] StWaitSpi = 3'd4;
    localparam logic [2:0] StResp    = 3'd5;
    localparam logic [2:0] StCsHold  = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [IdxW-1:0] len_q, len_d;
    logic            flag_q, flag_d;
    logic [IdxW-1:0] wr_idx_q, wr_idx_d;
    logic [IdxW-1:0] rd_idx_q, rd_idx_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      spi_tx_data_q, spi_tx_data_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            spi_start_q, spi_start_d;
    logic            tx_start_q, tx_start_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      mem_q [MAX_LEN];
    logic            mem_we;
    logic [4:0]      hdr_len;
    logic            hdr_ok;
    logic [IdxW-1:0] rd_next;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        flag_d        = flag_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        tmo_d         = tmo_q;
        spi_tx_data_d = spi_tx_data_q;
        tx_data_d     = tx_data_q;
        spi_start_d   = 1'b0;
        tx_start_d    = 1'b0;
        frame_err_d   = 1'b0;
        mem_we        = 1'b0;
        hdr_len       = {1'b0, rx_data_i[3:0]} + 5'd1;
        hdr_ok        = (rx_data_i[6:4] == 3'b000) && ({27'd0, hdr_len} <= MAX_LEN);
        rd_next       = rd_idx_q + IdxW'(1);

        case (state_q)
            StIdle: begin
                if (rx_done_i) begin
                    if (hdr_ok) begin
                        len_d    = IdxW'(hdr_len);
                        flag_d   = rx_data_i[7];
                        wr_idx_d = '0;
                        tmo_d    = '0;
                        state_d  = StCollect;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                // A byte landing on the expiry cycle is still accepted.
                if (rx_done_i) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + IdxW'(1);
                    tmo_d    = '0;
                    if (wr_idx_q + IdxW'(1) == len_q) begin
                        state_d = StCsSetup;
                    end
                end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    frame_err_d = 1'b1;
                    wr_idx_d    = '0;
                    tmo_d       = '0;
                    state_d     = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StCsSetup: begin
                rd_idx_d = '0;
                state_d  = StIssue;
            end
            StIssue: begin
                if (!spi_busy_i) begin
                    spi_tx_data_d = mem_q[rd_idx_q[AddrW-1:0]];
                    spi_start_d   = 1'b1;
                    state_d       = StWaitSpi;
                end
            end
            StWaitSpi: begin
                if (spi_done_i) begin
                    tx_data_d = spi_rx_data_i;
                    if (flag_q) begin
                        state_d = StResp;
                    end else begin
                        rd_idx_d = rd_next;
                        state_d  = (rd_next == len_q) ? StCsHold : StIssue;
                    end
                end
            end
            StResp: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    rd_idx_d   = rd_next;
                    state_d    = (rd_next == len_q) ? StCsHold : StIssue;
                end
            end
            StCsHold: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // UART bytes arriving while the SPI side owns the frame are dropped.
        if (rx_done_i && (state_q != StIdle) && (state_q != StCollect)) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            len_q         <= '0;
            flag_q        <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            tmo_q         <= '0;
            spi_tx_data_q <= '0;
            tx_data_q     <= '0;
            spi_start_q   <= 1'b0;
            tx_start_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            flag_q        <= flag_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            tmo_q         <= tmo_d;
            spi_tx_data_q <= spi_tx_data_d;
            tx_data_q     <= tx_data_d;
            spi_start_q   <= spi_start_d;
            tx_start_q    <= tx_start_d;
            frame_err_q   <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx_q[AddrW-1:0]] <= rx_data_i;
        end
    end

    assign spi_cs_n_o    = (state_q == StIdle) || (state_q == StCollect);
    assign busy_o        = (state_q != StIdle);
    assign spi_start_o   = spi_start_q;
    assign spi_tx_data_o = spi_tx_data_q;
    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign frame_err_o   = frame_err_q;

endmodule
